// File: rtl/grf_scoreboard_if.sv
// Decode/writeback-side bundle of the general-register scoreboard.
// The CPU pipeline is the master; the register file is the slave.
interface grf_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     issue_en;
    logic [ADDR_W-1:0]        issue_addr;
    logic                     issue_ready;
    logic                     flush;
    logic                     stall;
    logic [(1<<ADDR_W)-1:0]   busy_vec;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
        input  rd_data, issue_ready, stall, busy_vec
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
        output rd_data, issue_ready, stall, busy_vec
    );
endinterface

// File: rtl/grf_scoreboard.sv
// General-register file with combinational read ports, write-to-read bypass,
// r0 hard-wired to zero, and a per-register pending-write counter that
// drives the decode-stage stall.
module grf_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    grf_scoreboard_if.slave   bus
);
    localparam int              NREG    = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [CNT_W-1:0]  cnt_q  [NREG];
    logic [CNT_W-1:0]  cnt_d  [NREG];
    logic [ADDR_W-1:0] ra     [NUM_RD];
    logic [NUM_RD-1:0] hazard;
    logic              issue_ready_w;

    // Unpack the per-port read addresses.
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_ra
        assign ra[gi] = bus.rd_addr[gi*ADDR_W +: ADDR_W];
    end

    // Register storage; writes to r0 are dropped so it always reads as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else if (bus.wr_en && bus.wr_addr != '0) begin
            regs_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Read ports with writeback bypass, plus per-port hazard detection.
    // A port whose only outstanding write is being written back right now
    // is not hazarded: the bypass already supplies the fresh value.
    always_comb begin
        bus.rd_data = '0;
        hazard      = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (ra[p] == '0) begin
                bus.rd_data[p*DATA_W +: DATA_W] = '0;
            end else if (bus.wr_en && bus.wr_addr == ra[p]) begin
                bus.rd_data[p*DATA_W +: DATA_W] = bus.wr_data;
            end else begin
                bus.rd_data[p*DATA_W +: DATA_W] = regs_q[ra[p]];
            end
            hazard[p] = bus.rd_en[p] && (ra[p] != '0) && (cnt_q[ra[p]] != '0)
                        && !((cnt_q[ra[p]] == CNT_ONE) && bus.wr_en && (bus.wr_addr == ra[p]));
        end
    end

    // Issue acceptance and next-state of every pending-write counter.
    // Flush wins over everything; simultaneous inc/dec cancel out.
    always_comb begin
        issue_ready_w = (bus.issue_addr == '0) || (cnt_q[bus.issue_addr] != CNT_MAX);
        for (int r = 0; r < NREG; r++) begin
            logic inc;
            logic dec;
            inc = bus.issue_en && issue_ready_w && (bus.issue_addr == ADDR_W'(r)) && (r != 0);
            dec = bus.wr_en && (bus.wr_addr == ADDR_W'(r)) && (cnt_q[r] != '0);
            cnt_d[r] = cnt_q[r];
            if (bus.flush || r == 0) begin
                cnt_d[r] = '0;
            end else if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (dec && !inc) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
    end

    // Pending-write counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Status outputs.
    always_comb begin
        bus.stall       = |hazard;
        bus.issue_ready = issue_ready_w;
        bus.busy_vec    = '0;
        for (int r = 1; r < NREG; r++) begin
            bus.busy_vec[r] = (cnt_q[r] != '0);
        end
    end
endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed bench for grf_scoreboard: a default 2-port/32-bit instance and a
// 3-port/16-bit instance sharing clock and reset.
module tb_grf_scoreboard;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;

    grf_scoreboard_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus_a ();
    grf_scoreboard_if #(.DATA_W(16), .ADDR_W(5), .NUM_RD(3)) bus_b ();

    grf_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .CNT_W(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    grf_scoreboard #(.DATA_W(16), .ADDR_W(5), .NUM_RD(3), .CNT_W(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_a();
        bus_a.rd_en = '0; bus_a.rd_addr = '0; bus_a.wr_en = 1'b0; bus_a.wr_addr = '0;
        bus_a.wr_data = '0; bus_a.issue_en = 1'b0; bus_a.issue_addr = '0; bus_a.flush = 1'b0;
    endtask

    task automatic idle_b();
        bus_b.rd_en = '0; bus_b.rd_addr = '0; bus_b.wr_en = 1'b0; bus_b.wr_addr = '0;
        bus_b.wr_data = '0; bus_b.issue_en = 1'b0; bus_b.issue_addr = '0; bus_b.flush = 1'b0;
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 2 ns later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue_a(input logic [4:0] a);
        bus_a.issue_en = 1'b1; bus_a.issue_addr = a;
        tick();
        bus_a.issue_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_a(); idle_b();
        bus_a.rd_en = 2'b11;
        bus_a.rd_addr = {5'd0, 5'd5};
        #2;
        n_vec++; if (bus_a.rd_data[31:0] !== 32'h0) begin n_bad++; $display("FAIL reset_rd0: got %h expected %h", bus_a.rd_data[31:0], 32'h0); end
        n_vec++; if (bus_a.rd_data[63:32] !== 32'h0) begin n_bad++; $display("FAIL reset_rd1: got %h expected %h", bus_a.rd_data[63:32], 32'h0); end
        tick();
        reset = 1'b0;
        #1;
        n_vec++; if (bus_a.stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b expected 0", bus_a.stall); end
        n_vec++; if (bus_a.busy_vec !== 32'h0) begin n_bad++; $display("FAIL reset_busy: got %h expected 0", bus_a.busy_vec); end
        n_vec++; if (bus_a.issue_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", bus_a.issue_ready); end
        $display("test_reset: done");
    endtask

    task automatic test_bypass();
        idle_a();
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd8; bus_a.wr_data = 32'hDEADBEEF;
        bus_a.rd_addr = {5'd0, 5'd8};
        #1;
        n_vec++; if (bus_a.rd_data[31:0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL bypass_r8: got %h expected %h", bus_a.rd_data[31:0], 32'hDEADBEEF); end
        tick();
        bus_a.wr_en = 1'b0; bus_a.wr_data = 32'h0;
        #1;
        n_vec++; if (bus_a.rd_data[31:0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL stored_r8: got %h expected %h", bus_a.rd_data[31:0], 32'hDEADBEEF); end
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd0; bus_a.wr_data = 32'h1234;
        #1;
        n_vec++; if (bus_a.rd_data[63:32] !== 32'h0) begin n_bad++; $display("FAIL r0_nobypass: got %h expected 0", bus_a.rd_data[63:32]); end
        n_vec++; if (bus_a.rd_data[31:0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL r8_during_r0wr: got %h expected %h", bus_a.rd_data[31:0], 32'hDEADBEEF); end
        tick();
        bus_a.wr_en = 1'b0;
        #1;
        n_vec++; if (bus_a.rd_data[63:32] !== 32'h0) begin n_bad++; $display("FAIL r0_after_wr: got %h expected 0", bus_a.rd_data[63:32]); end
        $display("test_bypass: done");
    endtask

    task automatic test_issue_stall();
        idle_a();
        issue_a(5'd3);
        n_vec++; if (bus_a.busy_vec[3] !== 1'b1) begin n_bad++; $display("FAIL issue_busy3: got %b expected 1", bus_a.busy_vec[3]); end
        bus_a.rd_addr = {5'd0, 5'd3}; bus_a.rd_en = 2'b01;
        #1;
        n_vec++; if (bus_a.stall !== 1'b1) begin n_bad++; $display("FAIL stall_r3: got %b expected 1", bus_a.stall); end
        bus_a.rd_en = 2'b00;
        #1;
        n_vec++; if (bus_a.stall !== 1'b0) begin n_bad++; $display("FAIL stall_gated: got %b expected 0", bus_a.stall); end
        bus_a.rd_en = 2'b01;
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd3; bus_a.wr_data = 32'h55;
        #1;
        n_vec++; if (bus_a.stall !== 1'b0) begin n_bad++; $display("FAIL stall_wb3: got %b expected 0", bus_a.stall); end
        n_vec++; if (bus_a.rd_data[31:0] !== 32'h55) begin n_bad++; $display("FAIL data_wb3: got %h expected %h", bus_a.rd_data[31:0], 32'h55); end
        tick();
        bus_a.wr_en = 1'b0;
        #1;
        n_vec++; if (bus_a.busy_vec[3] !== 1'b0) begin n_bad++; $display("FAIL busy3_clear: got %b expected 0", bus_a.busy_vec[3]); end
        n_vec++; if (bus_a.rd_data[31:0] !== 32'h55) begin n_bad++; $display("FAIL stored_r3: got %h expected %h", bus_a.rd_data[31:0], 32'h55); end
        $display("test_issue_stall: done");
    endtask

    // Saturate r4 (cnt=3), then drain it; issue+writeback together is done at
    // cnt=2, where the issue is accepted and the counter must stay at 2.
    task automatic test_saturate();
        idle_a();
        issue_a(5'd4);
        issue_a(5'd4);
        bus_a.issue_addr = 5'd4;
        #1;
        n_vec++; if (bus_a.issue_ready !== 1'b1) begin n_bad++; $display("FAIL ready_cnt2: got %b expected 1", bus_a.issue_ready); end
        issue_a(5'd4);
        n_vec++; if (bus_a.issue_ready !== 1'b0) begin n_bad++; $display("FAIL ready_cnt3: got %b expected 0", bus_a.issue_ready); end
        issue_a(5'd4);
        n_vec++; if (bus_a.issue_ready !== 1'b0) begin n_bad++; $display("FAIL ready_after_4th: got %b expected 0", bus_a.issue_ready); end
        bus_a.rd_en = 2'b01; bus_a.rd_addr = {5'd0, 5'd4};
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd4; bus_a.wr_data = 32'h41;
        #1;
        n_vec++; if (bus_a.stall !== 1'b1) begin n_bad++; $display("FAIL stall_wb_cnt3: got %b expected 1", bus_a.stall); end
        tick();
        n_vec++; if (bus_a.issue_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_wb: got %b expected 1", bus_a.issue_ready); end
        bus_a.issue_en = 1'b1; bus_a.wr_data = 32'h42;
        tick();
        bus_a.issue_en = 1'b0;
        n_vec++; if (bus_a.issue_ready !== 1'b1) begin n_bad++; $display("FAIL ready_inc_dec: got %b expected 1", bus_a.issue_ready); end
        bus_a.wr_data = 32'h43;
        #1;
        n_vec++; if (bus_a.stall !== 1'b1) begin n_bad++; $display("FAIL stall_wb_cnt2: got %b expected 1", bus_a.stall); end
        tick();
        bus_a.wr_data = 32'h44;
        #1;
        n_vec++; if (bus_a.stall !== 1'b0) begin n_bad++; $display("FAIL stall_last_wb: got %b expected 0", bus_a.stall); end
        n_vec++; if (bus_a.rd_data[31:0] !== 32'h44) begin n_bad++; $display("FAIL data_last_wb: got %h expected %h", bus_a.rd_data[31:0], 32'h44); end
        n_vec++; if (bus_a.busy_vec[4] !== 1'b1) begin n_bad++; $display("FAIL busy4_before_edge: got %b expected 1", bus_a.busy_vec[4]); end
        tick();
        bus_a.wr_en = 1'b0;
        #1;
        n_vec++; if (bus_a.busy_vec !== 32'h0) begin n_bad++; $display("FAIL busy_drained: got %h expected 0", bus_a.busy_vec); end
        $display("test_saturate: done");
    endtask

    task automatic test_flush();
        idle_a();
        issue_a(5'd2);
        issue_a(5'd7);
        issue_a(5'd9);
        n_vec++; if (bus_a.busy_vec !== 32'h0000_0284) begin n_bad++; $display("FAIL busy_279: got %h expected %h", bus_a.busy_vec, 32'h284); end
        bus_a.flush = 1'b1; bus_a.issue_en = 1'b1; bus_a.issue_addr = 5'd10;
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd7; bus_a.wr_data = 32'h77;
        tick();
        idle_a();
        bus_a.rd_en = 2'b01; bus_a.rd_addr = {5'd0, 5'd7};
        #1;
        n_vec++; if (bus_a.busy_vec !== 32'h0) begin n_bad++; $display("FAIL busy_flushed: got %h expected 0", bus_a.busy_vec); end
        n_vec++; if (bus_a.rd_data[31:0] !== 32'h77) begin n_bad++; $display("FAIL flush_wb_r7: got %h expected %h", bus_a.rd_data[31:0], 32'h77); end
        n_vec++; if (bus_a.stall !== 1'b0) begin n_bad++; $display("FAIL stall_flushed: got %b expected 0", bus_a.stall); end
        $display("test_flush: done");
    endtask

    task automatic test_wide_async_reset();
        idle_b();
        bus_b.wr_en = 1'b1; bus_b.wr_addr = 5'd1; bus_b.wr_data = 16'hABCD;
        tick();
        bus_b.wr_en = 1'b0;
        bus_b.issue_en = 1'b1; bus_b.issue_addr = 5'd12;
        tick();
        bus_b.issue_en = 1'b0;
        bus_b.rd_en = 3'b111; bus_b.rd_addr = {5'd12, 5'd0, 5'd1};
        #1;
        n_vec++; if (bus_b.stall !== 1'b1) begin n_bad++; $display("FAIL wide_stall_p2: got %b expected 1", bus_b.stall); end
        n_vec++; if (bus_b.rd_data[15:0] !== 16'hABCD) begin n_bad++; $display("FAIL wide_rd_p0: got %h expected %h", bus_b.rd_data[15:0], 16'hABCD); end
        bus_b.rd_en = 3'b011;
        #1;
        n_vec++; if (bus_b.stall !== 1'b0) begin n_bad++; $display("FAIL wide_stall_clean: got %b expected 0", bus_b.stall); end
        bus_b.rd_en = 3'b111;
        #1;
        reset = 1'b1;
        #1;
        n_vec++; if (bus_b.stall !== 1'b0) begin n_bad++; $display("FAIL async_stall: got %b expected 0", bus_b.stall); end
        n_vec++; if (bus_b.rd_data !== 48'h0) begin n_bad++; $display("FAIL async_rd: got %h expected 0", bus_b.rd_data); end
        n_vec++; if (bus_b.busy_vec !== 32'h0) begin n_bad++; $display("FAIL async_busy: got %h expected 0", bus_b.busy_vec); end
        n_vec++; if (bus_a.rd_data[31:0] !== 32'h0) begin n_bad++; $display("FAIL async_rd_a: got %h expected 0", bus_a.rd_data[31:0]); end
        #1;
        reset = 1'b0;
        $display("test_wide_async_reset: done");
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        test_reset();
        test_bypass();
        test_issue_stall();
        test_saturate();
        test_flush();
        test_wide_async_reset();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
